// File: rtl/disp_arbiter_pkg.sv
// Shared types and constants for the display arbiter: state encoding, source
// count, word width, digit-index width and the round-robin search helper.
package disp_arbiter_pkg;

    localparam int NUM_SRC = 4;
    localparam int WORD_W  = 16;
    localparam int DIG_W   = 2;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Returns {found, index} of the first set request at or after start, wrapping.
    function automatic logic [IDX_W:0] pick_next(input logic [NUM_SRC-1:0] req,
                                                 input logic [IDX_W-1:0]   start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = start + IDX_W'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_arbiter_scan_timer.sv
// Digit-scan timer: prescaler producing the scan tick, plus the digit index
// whose wrap from 3 to 0 marks a frame boundary.
module disp_arbiter_scan_timer
    import disp_arbiter_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic scan_en,
    output logic frame_tick
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    count;
    logic [DIG_W-1:0] digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            digit <= '0;
        end else begin
            if (count == LAST) count <= '0;
            else               count <= count + PW'(1);
            if (scan_en) digit <= digit + DIG_W'(1);
        end
    end

    assign scan_en    = (count == LAST);
    assign frame_tick = scan_en && (digit == '1);

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner arbitration for a shared hex display; ownership and the
// displayed word change only at frame boundaries. Optional DISP_FREEZE_EN adds freeze.
//
// state | meaning
// IDLE  | no owner, display blanked, word_out holds last value
// OWN   | one source owns the display for a dwell of frames
module disp_arbiter
    import disp_arbiter_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DWELL    = 256
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef DISP_FREEZE_EN
    input  logic                      freeze,
`endif
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*WORD_W-1:0] words,
    output logic                      scan_en,
    output logic [WORD_W-1:0]         word_out,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      blank
);

    localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);

    state_t              state, state_nx;
    logic [NUM_SRC-1:0]  grant_nx;
    logic [WORD_W-1:0]   word_nx;
    logic [IDX_W-1:0]    rr_ptr, rr_nx;
    logic [IDX_W-1:0]    owner, owner_nx;
    logic [DW-1:0]       dwell, dwell_nx;
    logic [IDX_W-1:0]    search_start;
    logic                pick_ok;
    logic [IDX_W-1:0]    pick_idx;
    logic                frame_tick;
    logic                hold;
    logic [WORD_W-1:0]   src_word [NUM_SRC];

`ifdef DISP_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    disp_arbiter_scan_timer #(.PRESCALE(PRESCALE)) scan_timer (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .frame_tick (frame_tick)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) src_word[i] = words[i*WORD_W +: WORD_W];
    end

    // An owner searches from its successor, so a sole requester comes back to itself last.
    assign search_start        = (state == OWN) ? owner + IDX_W'(1) : rr_ptr;
    assign {pick_ok, pick_idx} = pick_next(req, search_start);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        word_nx  = word_out;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        dwell_nx = dwell;
        if (frame_tick && !hold) begin
            if (state == OWN && req[owner] && dwell != '0) begin
                dwell_nx = dwell - DW'(1);
                word_nx  = src_word[owner];
            end else if (pick_ok) begin
                state_nx = OWN;
                owner_nx = pick_idx;
                grant_nx = NUM_SRC'(1) << pick_idx;
                word_nx  = src_word[pick_idx];
                rr_nx    = pick_idx + IDX_W'(1);
                dwell_nx = DWELL_LOAD;
            end else begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            word_out <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            dwell    <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            word_out <= word_nx;
            rr_ptr   <= rr_nx;
            owner    <= owner_nx;
            dwell    <= dwell_nx;
        end
    end

    assign blank = (state == IDLE);

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: frame-level ownership model compared every cycle,
// plus directed scenarios with literal expectations (freeze part under DISP_FREEZE_EN).
module tb_disp_arbiter;

    localparam int PRESCALE = 4;
    localparam int DWELL    = 2;
    localparam int FRAME    = PRESCALE * 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [63:0] words = '0;
`ifdef DISP_FREEZE_EN
    logic        freeze = 1'b0;
`endif
    logic        scan_en;
    logic [15:0] word_out;
    logic [3:0]  grant;
    logic        blank;

    int total = 0;
    int bad   = 0;

    // model: owner index (-1 idle), frames held, round-robin start, shown word
    int          m_cyc    = 0;
    int          m_owner  = -1;
    int          m_held   = 0;
    int          m_rr     = 0;
    int          m_frames = 0;
    logic [15:0] m_word   = '0;

    always #5 clk = ~clk;

    disp_arbiter #(.PRESCALE(PRESCALE), .DWELL(DWELL)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef DISP_FREEZE_EN
        .freeze   (freeze),
`endif
        .req      (req),
        .words    (words),
        .scan_en  (scan_en),
        .word_out (word_out),
        .grant    (grant),
        .blank    (blank)
    );

    function automatic logic [15:0] word_of(int s);
        return words[s*16 +: 16];
    endfunction

    function automatic logic [3:0] m_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_pick(int start);
        bit found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int s = (start + k) % 4;
            if (!found && req[s]) begin
                found   = 1'b1;
                m_owner = s;
                m_held  = 1;
                m_rr    = (s + 1) % 4;
                m_word  = word_of(s);
            end
        end
        if (!found) m_owner = -1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_cyc = 0; m_owner = -1; m_held = 0; m_rr = 0; m_word = '0;
            end else begin
                bit boundary;
                bit frz;
`ifdef DISP_FREEZE_EN
                frz = freeze;
`else
                frz = 1'b0;
`endif
                boundary = (m_cyc % FRAME) == FRAME - 1;
                m_cyc++;
                if (boundary) begin
                    m_frames++;
                    if (!frz) begin
                        if (m_owner < 0)                                m_pick(m_rr);
                        else if (req[m_owner] && m_held < DWELL) begin
                            m_held++;
                            m_word = word_of(m_owner);
                        end else                                        m_pick(m_owner + 1);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("scan_en",  32'(scan_en),  32'((m_cyc % PRESCALE) == PRESCALE - 1));
            check("grant",    32'(grant),    32'(m_grant()));
            check("blank",    32'(blank),    32'(m_owner < 0));
            check("word_out", 32'(word_out), 32'(m_word));
        end
    end

    task automatic lit(string name, logic [3:0] eg, logic [15:0] ew, logic eb);
        check({name, "_grant"},   32'(grant),        32'(eg));
        check({name, "_word"},    32'(word_out),     32'(ew));
        check({name, "_blank"},   32'(blank),        32'(eb));
        check({name, "_m_grant"}, 32'(m_grant()),    32'(eg));
        check({name, "_m_word"},  32'(m_word),       32'(ew));
    endtask

    task automatic wait_frames(int n);
        int target = m_frames + n;
        int budget = n * FRAME + 4;
        while (m_frames < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("frame_wait", 32'(m_frames >= target), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0]  tab_g [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001};
    logic [15:0] tab_w [7] = '{16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h8888, 16'h8888, 16'h1111};

    initial begin
        int se_cnt = 0;
        int first  = -1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (scan_en) begin
                se_cnt++;
                if (first < 0) first = i;
            end
        end
        check("scan_count", 32'(se_cnt), 32'd25);
        check("scan_first", 32'(first),  32'd3);
        lit("idle", 4'b0000, 16'h0000, 1'b1);

        words[47:32] = 16'hBEEF;
        req = 4'b0100;
        wait_frames(1);
        lit("own2", 4'b0100, 16'hBEEF, 1'b0);
        wait_frames(3);
        lit("hold2", 4'b0100, 16'hBEEF, 1'b0);

        do_reset();
        words = {16'h8888, 16'h0000, 16'h2222, 16'h1111};
        req = 4'b1011;
        for (int i = 0; i < 7; i++) begin
            wait_frames(1);
            check("rot_grant", 32'(grant),    32'(tab_g[i]));
            check("rot_word",  32'(word_out), 32'(tab_w[i]));
        end

        do_reset();
        req = 4'b1011;
        wait_frames(3);
        lit("own1", 4'b0010, 16'h2222, 1'b0);
        req = 4'b1001;
        wait_frames(1);
        lit("drop1", 4'b1000, 16'h8888, 1'b0);
        req = 4'b0010;
        wait_frames(1);
        lit("back1", 4'b0010, 16'h2222, 1'b0);
        req = 4'b0000;
        wait_frames(1);
        lit("release", 4'b0000, 16'h2222, 1'b1);

        words[15:0] = 16'h1234;
        req = 4'b0001;
        wait_frames(1);
        lit("own0", 4'b0001, 16'h1234, 1'b0);
        repeat (4) @(negedge clk);
        words[15:0] = 16'h5678;
        repeat (3) @(negedge clk);
        check("midframe_word", 32'(word_out), 32'h1234);
        wait_frames(1);
        lit("reload0", 4'b0001, 16'h5678, 1'b0);

        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        lit("async_rst", 4'b0000, 16'h0000, 1'b1);
        check("async_rst_scan", 32'(scan_en), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

`ifdef DISP_FREEZE_EN
        words[15:0] = 16'hAAAA;
        req = 4'b0001;
        wait_frames(1);
        lit("frz_own", 4'b0001, 16'hAAAA, 1'b0);
        freeze = 1'b1;
        req = 4'b0011;
        words[15:0] = 16'hBBBB;
        for (int i = 0; i < 3; i++) begin
            wait_frames(1);
            lit("frz_hold", 4'b0001, 16'hAAAA, 1'b0);
        end
        freeze = 1'b0;
        wait_frames(1);
        lit("frz_resume", 4'b0001, 16'hBBBB, 1'b0);
        wait_frames(1);
        lit("frz_next", 4'b0010, 16'h2222, 1'b0);
`endif

        req = 4'b0000;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
